// File: rtl/vga_timing_gen.sv
// Raster timing generator: per-axis sync/porch/active counters with registered
// hsync, vsync, data-enable, pixel coordinates, an early fetch request and
// line/frame start pulses. Everything advances on the pixel enable.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CW       = 12,
    parameter int unsigned LEAD     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          req,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_ACT_START = H_SYNC + H_BP;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int unsigned V_ACT_START = V_SYNC + V_BP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE;

    // Reject geometries the counters or the lead-ahead decode cannot represent.
    if (LEAD > H_ACT_START) begin : g_bad_lead
        $fatal(1, "vga_timing_gen: LEAD exceeds H_SYNC+H_BP");
    end
    if (64'(H_TOTAL) >= (64'd1 << CW) || 64'(V_TOTAL) >= (64'd1 << CW)) begin : g_bad_cw
        $fatal(1, "vga_timing_gen: line or frame total does not fit in CW bits");
    end
    if (H_SYNC == 0 || H_ACTIVE == 0 || V_SYNC == 0 || V_ACTIVE == 0) begin : g_bad_zero
        $fatal(1, "vga_timing_gen: sync and active widths must be non-zero");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;

    logic          h_last_c;
    logic          v_last_c;
    logic          h_sync_c;
    logic          v_sync_c;
    logic          h_act_c;
    logic          v_act_c;
    logic [CW:0]   h_lead_c;
    logic          h_req_c;
    logic [CW-1:0] x_c;
    logic [CW-1:0] y_c;
    logic          ls_c;
    logic          fs_c;

    // Region decode of the current (pre-increment) counter position.
    always_comb begin
        h_last_c = (h_cnt == CW'(H_TOTAL - 1));
        v_last_c = (v_cnt == CW'(V_TOTAL - 1));
        h_sync_c = (h_cnt < CW'(H_SYNC));
        v_sync_c = (v_cnt < CW'(V_SYNC));
        h_act_c  = (h_cnt >= CW'(H_ACT_START)) && (h_cnt < CW'(H_ACT_END));
        v_act_c  = (v_cnt >= CW'(V_ACT_START)) && (v_cnt < CW'(V_ACT_END));
        // One extra bit so h_cnt+LEAD never wraps back into the active window.
        h_lead_c = {1'b0, h_cnt} + (CW+1)'(LEAD);
        h_req_c  = (h_lead_c >= (CW+1)'(H_ACT_START)) && (h_lead_c < (CW+1)'(H_ACT_END));
        x_c      = h_cnt - CW'(H_ACT_START);
        y_c      = v_cnt - CW'(V_ACT_START);
        ls_c     = (h_cnt == '0);
        fs_c     = (h_cnt == '0) && (v_cnt == '0);
    end

    // Horizontal and vertical position counters; vertical steps on line wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            h_cnt <= h_last_c ? '0 : h_cnt + CW'(1);
            if (h_last_c) begin
                v_cnt <= v_last_c ? '0 : v_cnt + CW'(1);
            end
        end
    end

    // Level outputs follow the decode on enabled cycles and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
            de    <= 1'b0;
            req   <= 1'b0;
            x     <= '0;
            y     <= '0;
        end else if (en) begin
            hsync <= h_sync_c ? HS_POL : ~HS_POL;
            vsync <= v_sync_c ? VS_POL : ~VS_POL;
            de    <= h_act_c && v_act_c;
            req   <= h_req_c && v_act_c;
            x     <= (h_act_c && v_act_c) ? x_c : '0;
            y     <= (h_act_c && v_act_c) ? y_c : '0;
        end
    end

    // Start pulses drop on the following clock even while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= en && ls_c;
            frame_start <= en && fs_c;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default mode, default with LEAD=2,
// small mode with active-high syncs) driven by a shared enable and reset,
// checked cycle by cycle against a linear-pixel-index reference model.
module tb_vga_timing_gen;

    localparam int unsigned CW = 12;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic          req;
        logic          ls;
        logic          fs;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
    } out_t;

    logic clk;
    logic rst_n;
    logic en;

    logic hs_a, vs_a, de_a, req_a, ls_a, fs_a;
    logic hs_b, vs_b, de_b, req_b, ls_b, fs_b;
    logic hs_c, vs_c, de_c, req_c, ls_c, fs_c;
    logic [CW-1:0] x_a, y_a, x_b, y_b, x_c, y_c;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .req(req_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(.LEAD(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .req(req_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .x(x_c), .y(y_c),
        .req(req_c), .line_start(ls_c), .frame_start(fs_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    out_t q_a[$];
    out_t q_b[$];
    out_t q_c[$];
    out_t prev_a, prev_b, prev_c;
    int   n_model;

    // measurement state (counted in enabled cycles since reset release)
    int          ec;
    bit          a_have_ls;
    int          a_ls_ec, a_hlow, a_vlow;
    bit          a_vs_done;
    bit          a_de_seen;
    int          b_req_rise, b_de_rise, b_req_fall, b_de_fall;
    bit          b_req_prev, b_de_prev;
    bit          c_have_ls, c_have_fs;
    int          c_ls_ec, c_fs_ec, c_hhigh, c_xi;
    logic [23:0] c_last_xy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic out_t model(input int n, input int hs_w, input int hbp, input int ha,
                                   input int hfp, input int vs_w, input int vbp, input int va,
                                   input int vfp, input bit hp, input bit vp, input int lead);
        out_t o;
        int   ht, vt, h, v;
        bit   hin, vin;
        ht    = hs_w + hbp + ha + hfp;
        vt    = vs_w + vbp + va + vfp;
        h     = n % ht;
        v     = (n / ht) % vt;
        hin   = (h >= hs_w + hbp) && (h < hs_w + hbp + ha);
        vin   = (v >= vs_w + vbp) && (v < vs_w + vbp + va);
        o.hs  = (h < hs_w) ? hp : ~hp;
        o.vs  = (v < vs_w) ? vp : ~vp;
        o.de  = hin && vin;
        o.req = vin && (h + lead >= hs_w + hbp) && (h + lead < hs_w + hbp + ha);
        o.x   = o.de ? CW'(h - hs_w - hbp) : '0;
        o.y   = o.de ? CW'(v - vs_w - vbp) : '0;
        o.ls  = (h == 0);
        o.fs  = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic out_t rst_val(input bit hp, input bit vp);
        out_t o;
        o    = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    function automatic out_t obs_a();
        return {hs_a, vs_a, de_a, req_a, ls_a, fs_a, x_a, y_a};
    endfunction
    function automatic out_t obs_b();
        return {hs_b, vs_b, de_b, req_b, ls_b, fs_b, x_b, y_b};
    endfunction
    function automatic out_t obs_c();
        return {hs_c, vs_c, de_c, req_c, ls_c, fs_c, x_c, y_c};
    endfunction

    task automatic clear_meas();
        ec         = 0;
        a_have_ls  = 0;
        a_hlow     = 0;
        a_vlow     = 0;
        a_vs_done  = 0;
        b_req_rise = -1;
        b_de_rise  = -1;
        b_req_fall = -1;
        b_de_fall  = -1;
        b_req_prev = 0;
        b_de_prev  = 0;
        c_have_ls  = 0;
        c_have_fs  = 0;
        c_hhigh    = 0;
        c_xi       = 0;
        c_last_xy  = '0;
    endtask

    // Expected values for the coming edge go into the scoreboard queues.
    task automatic push_expected(input logic e, input logic r);
        if (!r) begin
            n_model = 0;
            prev_a  = rst_val(1'b0, 1'b0);
            prev_b  = rst_val(1'b0, 1'b0);
            prev_c  = rst_val(1'b1, 1'b1);
        end else if (e) begin
            prev_a = model(n_model, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, 0);
            prev_b = model(n_model, 96, 48, 640, 16, 2, 33, 480, 10, 1'b0, 1'b0, 2);
            prev_c = model(n_model, 2, 1, 4, 1, 1, 1, 3, 1, 1'b1, 1'b1, 0);
            n_model++;
        end else begin
            prev_a.ls = 1'b0; prev_a.fs = 1'b0;
            prev_b.ls = 1'b0; prev_b.fs = 1'b0;
            prev_c.ls = 1'b0; prev_c.fs = 1'b0;
        end
        q_a.push_back(prev_a);
        q_b.push_back(prev_b);
        q_c.push_back(prev_c);
    endtask

    task automatic pop_compare();
        out_t ea, eb, ecc;
        ea  = q_a.pop_front();
        eb  = q_b.pop_front();
        ecc = q_c.pop_front();
        check("sb_a", {2'b0, obs_a()}, {2'b0, ea});
        check("sb_b", {2'b0, obs_b()}, {2'b0, eb});
        check("sb_c", {2'b0, obs_c()}, {2'b0, ecc});
    endtask

    // Geometry measurements taken on enabled edges only.
    task automatic measure();
        ec++;
        if (ls_a) begin
            if (a_have_ls) begin
                check("a_line_period", 32'(ec - a_ls_ec), 32'd800);
                check("a_hsync_low", 32'(a_hlow), 32'd96);
            end
            a_have_ls = 1;
            a_ls_ec   = ec;
            a_hlow    = 0;
        end
        if (!hs_a) a_hlow++;
        if (!a_vs_done) begin
            if (!vs_a) a_vlow++;
            else if (a_vlow > 0) begin
                check("a_vsync_low", 32'(a_vlow), 32'd1600);
                a_vs_done = 1;
            end
        end
        if (!a_de_seen && de_a) begin
            check("a_first_de_cycle", 32'(ec), 32'd28145);
            check("a_first_de_xy", 32'({x_a, y_a}), 32'd0);
            a_de_seen = 1;
        end

        if (req_b && !b_req_prev && b_req_rise < 0) b_req_rise = ec;
        if (de_b && !b_de_prev && b_de_rise < 0) begin
            b_de_rise = ec;
            check("b_req_rise_lead", 32'(b_de_rise - b_req_rise), 32'd2);
        end
        if (!req_b && b_req_prev && b_req_fall < 0) b_req_fall = ec;
        if (!de_b && b_de_prev && b_de_fall < 0) begin
            b_de_fall = ec;
            check("b_req_fall_lead", 32'(b_de_fall - b_req_fall), 32'd2);
        end
        b_req_prev = req_b;
        b_de_prev  = de_b;

        if (ec < 600) begin
            if (ls_c) begin
                if (c_have_ls) begin
                    check("c_line_period", 32'(ec - c_ls_ec), 32'd8);
                    check("c_hsync_high", 32'(c_hhigh), 32'd2);
                end
                c_have_ls = 1;
                c_ls_ec   = ec;
                c_hhigh   = 0;
            end
            if (hs_c) c_hhigh++;
            if (fs_c) begin
                if (c_have_fs) begin
                    check("c_frame_period", 32'(ec - c_fs_ec), 32'd48);
                    check("c_last_de_xy", 32'(c_last_xy), 32'({12'd3, 12'd2}));
                end
                c_have_fs = 1;
                c_fs_ec   = ec;
            end
            if (de_c) begin
                check("c_x_seq", 32'(x_c), 32'(c_xi));
                c_xi++;
                c_last_xy = {x_c, y_c};
            end else begin
                c_xi = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic tick(input logic e, input logic r);
        @(negedge clk);
        rst_n = r;
        en    = e;
        push_expected(e, r);
        @(posedge clk);
        #1;
        pop_compare();
        if (e && r) measure();
    endtask

    logic [25:0] saved;

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        a_de_seen = 0;
        n_model   = 0;
        clear_meas();

        // reset held
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        check("rst_a", {2'b0, obs_a()}, {2'b0, rst_val(1'b0, 1'b0)});
        check("rst_c", {2'b0, obs_c()}, {2'b0, rst_val(1'b1, 1'b1)});

        // first enabled edge after release
        tick(1'b1, 1'b1);
        check("first_fs_a", 32'(fs_a), 32'd1);
        check("first_ls_a", 32'(ls_a), 32'd1);
        check("first_syncs_a", 32'({hs_a, vs_a}), 32'd0);
        check("first_syncs_c", 32'({hs_c, vs_c}), 32'd3);
        tick(1'b1, 1'b1);
        check("fs_a_width", 32'({fs_a, ls_a}), 32'd0);

        // en drops right after a small-mode frame start
        for (int i = 0; i < 100 && !fs_c; i++) tick(1'b1, 1'b1);
        check("c_fs_found", 32'(fs_c), 32'd1);
        tick(1'b0, 1'b1);
        check("c_fs_one_clk", 32'({fs_c, ls_c}), 32'd0);
        tick(1'b0, 1'b1);

        // run to the first visible pixel of the default mode
        for (int i = 0; i < 30000 && !a_de_seen; i++) tick(1'b1, 1'b1);
        check("a_de_reached", 32'(a_de_seen), 32'd1);

        // stall at x=100
        for (int i = 0; i < 200 && !(de_a && x_a == CW'(100)); i++) tick(1'b1, 1'b1);
        check("a_x100_found", 32'(x_a), 32'd100);
        saved = {de_a, x_a, y_a, hs_a};
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1);
            check("a_stall_hold", 32'({de_a, x_a, y_a, hs_a}), 32'(saved));
        end

        // irregular enable pattern
        for (int i = 0; i < 300; i++) tick(1'(($urandom_range(0, 3) != 0)), 1'b1);

        // asynchronous reset in the middle of a visible line
        for (int i = 0; i < 1000 && !(de_a && x_a == CW'(300)); i++) tick(1'b1, 1'b1);
        check("a_x300_found", 32'(x_a), 32'd300);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", {2'b0, obs_a()}, {2'b0, rst_val(1'b0, 1'b0)});
        check("async_rst_b", {2'b0, obs_b()}, {2'b0, rst_val(1'b0, 1'b0)});
        check("async_rst_c", {2'b0, obs_c()}, {2'b0, rst_val(1'b1, 1'b1)});
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0);
        clear_meas();
        tick(1'b1, 1'b1);
        check("restart_fs", 32'({fs_a, fs_b, fs_c}), 32'd7);
        for (int i = 0; i < 100; i++) tick(1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
